// File: rtl/uart_receiver.sv
// UART receiver: oversampled start validation, mid-bit sampling, framing check.
module uart_receiver #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS) + 1;

  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_next;

  logic rx_meta, rx_s;

  logic [TICK_W-1:0]    tick_cnt, tick_cnt_next;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 data_valid_next, framing_error_next, busy_next;

  logic tick_at_mid, tick_at_end;

  assign tick_at_mid = (tick_cnt == TICK_MID);
  assign tick_at_end = (tick_cnt == TICK_END);

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; only ticks move the FSM.
  always_comb begin
    state_next = state;
    if (sample_tick) begin
      case (state)
        S_IDLE:  if (!rx_s) state_next = S_START;
        S_START: if (tick_at_mid) state_next = rx_s ? S_IDLE : S_DATA;
        S_DATA:  if (tick_at_end && (bit_cnt == BIT_LAST)) state_next = S_STOP;
        S_STOP:  if (tick_at_end) state_next = rx_s ? S_IDLE : S_BREAK;
        S_BREAK: if (rx_s) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Counter, shift register and strobe next values.
  always_comb begin
    tick_cnt_next      = tick_cnt;
    bit_cnt_next       = bit_cnt;
    shift_next         = shift;
    data_next          = data;
    data_valid_next    = 1'b0;
    framing_error_next = 1'b0;
    busy_next          = (state_next != S_IDLE);
    if (sample_tick) begin
      case (state)
        S_IDLE: begin
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
        end
        S_START: begin
          tick_cnt_next = tick_at_mid ? '0 : tick_cnt + TICK_W'(1);
          bit_cnt_next  = '0;
        end
        S_DATA: begin
          if (tick_at_end) begin
            shift_next    = {rx_s, shift[DATA_BITS-1:1]};
            tick_cnt_next = '0;
            bit_cnt_next  = bit_cnt + BIT_W'(1);
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
        S_STOP: begin
          if (tick_at_end) begin
            tick_cnt_next = '0;
            if (rx_s) begin
              data_next       = shift;
              data_valid_next = 1'b1;
            end else begin
              framing_error_next = 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
        default: tick_cnt_next = '0;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      tick_cnt      <= tick_cnt_next;
      bit_cnt       <= bit_cnt_next;
      shift         <= shift_next;
      data          <= data_next;
      data_valid    <= data_valid_next;
      framing_error <= framing_error_next;
      busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames
// compared against a frame-level expectation model.
`timescale 1ns/1ps
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       uart_rx;
  logic       sample_tick;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .sample_tick   (sample_tick),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  typedef struct packed {
    logic       fe;
    logic [7:0] d;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         valid_cyc = 0;
  int         tick_period = 1;
  int         bit_clks = 16;
  bit         busy_seen = 0;
  logic [7:0] last_good = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sample_tick generator: one-clk pulse every tick_period clocks.
  initial begin
    int tick_ctr;
    tick_ctr    = 0;
    sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_ctr++;
      sample_tick = ((tick_ctr % tick_period) == 0);
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (data_valid && framing_error) check("strobe_exclusive", 1, 0);
    if (data_valid) begin
      got_q.push_back('{fe: 1'b0, d: data});
      valid_cyc = cyc;
    end
    if (framing_error) got_q.push_back('{fe: 1'b1, d: data});
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_tick_period(input int p);
    tick_period = p;
    bit_clks    = 16 * p;
  endtask

  // Frame-level model: a good frame yields its byte, a low stop bit yields a
  // framing error with data still showing the last good byte.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      exp_q.push_back('{fe: 1'b0, d: b});
      last_good = b;
    end else begin
      exp_q.push_back('{fe: 1'b1, d: last_good});
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      wait_clks(bit_clks);
    end
  endtask

  task automatic compare_events(input string tag);
    wait_clks(2 * bit_clks);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_kind"}, 32'(got_q[i].fe), 32'(exp_q[i].fe));
      check({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic random_batch(input string tag, input int n);
    logic [7:0] b;
    bit         ok;
    int         gap;
    for (int i = 0; i < n; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      model_frame(b, ok);
      send_frame(b, ok);
      uart_rx = 1'b1;
      if (!ok) gap = bit_clks * (1 + $urandom_range(0, 2));
      else if ($urandom_range(0, 1) == 0) gap = 0;
      else gap = $urandom_range(1, 40);
      if (gap > 0) wait_clks(gap);
    end
    compare_events(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    uart_rx = 1'b1;
    reset   = 1'b1;
    set_tick_period(1);
    wait_clks(4);
    reset = 1'b0;
    @(negedge clk);
    check("reset_data", 32'(data), 0);
    check("reset_valid", 32'(data_valid), 0);
    check("reset_ferr", 32'(framing_error), 0);
    check("reset_busy", 32'(busy), 0);
    wait_clks(4);

    // Single 0xA5 frame with latency from the falling edge.
    model_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1);
    compare_events("a5");
    check("a5_latency", 32'((valid_cyc - fall_cyc) >= 152 && (valid_cyc - fall_cyc) <= 158), 1);
    check("a5_busy_after", 32'(busy), 0);

    // Short low glitch: start is entered and then abandoned.
    busy_seen = 1'b0;
    uart_rx = 1'b0;
    wait_clks(4);
    uart_rx = 1'b1;
    wait_clks(40);
    check("glitch_busy_seen", 32'(busy_seen), 1);
    check("glitch_busy_after", 32'(busy), 0);
    check("glitch_data_kept", 32'(data), 32'(last_good));
    compare_events("glitch");

    // Low stop bit, line held low: error once, busy until the line recovers.
    model_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);
    wait_clks(100 - bit_clks);
    check("break_busy_held", 32'(busy), 1);
    check("break_event_count", got_q.size(), 1);
    uart_rx = 1'b1;
    wait_clks(10);
    check("break_busy_release", 32'(busy), 0);
    check("break_data_kept", 32'(data), 32'(last_good));
    compare_events("break");

    // Back-to-back frames with no idle gap.
    model_frame(8'h00, 1'b1);
    model_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    uart_rx = 1'b1;
    compare_events("b2b");

    // Reset during data bit 4 of 0x5A, line recovered, then 0xC3.
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
        uart_rx = bits[i];
        wait_clks(bit_clks);
      end
      uart_rx = bits[5];
      wait_clks(bit_clks / 2);
      reset = 1'b1;
      wait_clks(1);
      reset = 1'b0;
      @(negedge clk);
      check("midreset_data", 32'(data), 0);
      check("midreset_valid", 32'(data_valid), 0);
      check("midreset_ferr", 32'(framing_error), 0);
      check("midreset_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      uart_rx = 1'b1;
      last_good = 8'h00;
      wait_clks(20 * bit_clks);
      model_frame(8'hC3, 1'b1);
      send_frame(8'hC3, 1'b1);
      compare_events("midreset");
    end

    // Random frames at two tick rates.
    random_batch("rand_t1", 20);
    set_tick_period(2);
    wait_clks(bit_clks);
    random_batch("rand_t2", 12);

    // Transmitter-style loopback: tick every 3 clk, 16 ticks per bit.
    set_tick_period(3);
    wait_clks(2 * bit_clks);
    begin
      logic [7:0] lb [4];
      lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hAA; lb[3] = 8'hFF;
      for (int i = 0; i < 4; i++) begin
        model_frame(lb[i], 1'b1);
        send_frame(lb[i], 1'b1);
      end
      uart_rx = 1'b1;
      compare_events("loopback");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
